// File: rtl/switch_adder_ctrl_if.sv
// Switch/adder/LED bundle for switch_adder_ctrl; master is the controller side,
// slave is the board/adder side.
interface switch_adder_ctrl_if;
  logic [7:0] switch;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] sum_in;
  logic [4:0] led;
  logic       busy;
  logic       done;

  modport master (
    input  switch, sum_in,
    output op_a, op_b, led, busy, done
  );

  modport slave (
    output switch, sum_in,
    input  op_a, op_b, led, busy, done
  );
endinterface

// File: rtl/switch_adder_ctrl.sv
// Debounced switch -> nibble adder -> LED sequencer; led/done valid DEBOUNCE_CYCLES+4 edges
// after a switch change, no backpressure. Optional CARRY_BLINK_EN blinks the carry LED.
module switch_adder_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV       = 8
) (
  input  logic                clk,
  input  logic                rst,
  switch_adder_ctrl_if.master bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be at least 1");
  end

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] cand;
  logic [7:0] committed;
  logic [7:0] cnt;
  logic       pending;
  logic [3:0] op_a_q;
  logic [3:0] op_b_q;
  logic [4:0] led_q;
  logic       done_q;
  logic       commit_evt;
  logic       load;
  logic       sample;
  logic [7:0] load_val;

  // A commit fires only on the edge where a new stable value is first accepted.
  assign commit_evt = (sync2 == cand) && (cnt == CNT_MAX) && (cand != committed);
  assign load_val   = commit_evt ? cand : committed;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (commit_evt || pending) begin
          load      = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE:   state_nxt = SAMPLE;
      SAMPLE: begin
        sample    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      committed <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      sync1 <= bus.switch;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end else if (cand != committed) begin
        committed <= cand;
      end
      // Commits during DRIVE/SAMPLE collapse into one pending request; committed holds the latest.
      if (load)            pending <= 1'b0;
      else if (commit_evt) pending <= 1'b1;
      if (load) begin
        op_a_q <= load_val[7:4];
        op_b_q <= load_val[3:0];
      end
      if (sample) led_q <= bus.sum_in;
      done_q <= sample;
    end
  end

  assign bus.op_a = op_a_q;
  assign bus.op_b = op_b_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

`ifdef CARRY_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (rst || sample) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign bus.led = {led_q[4] & blink_on, led_q[3:0]};
`else
  assign bus.led = led_q;
`endif

endmodule

// File: tb/tb_switch_adder_ctrl.sv
// Two controllers (debounce 4 and 1) share one switch stream and are checked each cycle
// against a latency/queueing model of the controller.
module tb_switch_adder_ctrl;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;

  switch_adder_ctrl_if bus0 ();
  switch_adder_ctrl_if bus1 ();

  assign bus0.switch = sw;
  assign bus1.switch = sw;
  assign bus0.sum_in = {1'b0, bus0.op_a} + {1'b0, bus0.op_b};
  assign bus1.sum_in = {1'b0, bus1.op_a} + {1'b0, bus1.op_b};

  switch_adder_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_DIV(BLINK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  switch_adder_ctrl #(.DEBOUNCE_CYCLES(1), .BLINK_DIV(BLINK_DIV)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  always #5 clk = ~clk;

  logic [14:0] obs [2];
  assign obs[0] = {bus0.op_a, bus0.op_b, bus0.led, bus0.busy, bus0.done};
  assign obs[1] = {bus1.op_a, bus1.op_b, bus1.led, bus1.busy, bus1.done};

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a value commits once D+1 consecutive sampled values agree (2-flop sync delay),
  // the controller loads when free, shows the sum 2 edges later, and is free again 1 edge after.
  logic [7:0] hist    [2][16];
  logic [7:0] comm    [2];
  logic [7:0] op_m    [2];
  logic [4:0] led_m   [2];
  logic       done_m  [2];
  logic       pend    [2];
  int         ld_at   [2];
  int         free_at [2];
  int         smp_at  [2];
  int         k = 0;

  task automatic tick();
    logic [7:0] s;
    logic       r;
    logic [7:0] v;
    logic       c;
    int         d;
    s = sw;
    r = rst;
    @(posedge clk);
    k++;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        for (int j = 0; j < 16; j++) hist[i][j] = 8'h00;
        comm[i] = 8'h00; op_m[i] = 8'h00; led_m[i] = 5'd0; done_m[i] = 1'b0;
        pend[i] = 1'b0; ld_at[i] = -100; free_at[i] = 0; smp_at[i] = k;
      end else begin
        d = (i == 0) ? 4 : 1;
        v = hist[i][1];
        c = (v != comm[i]);
        for (int j = 2; j <= d + 1; j++) if (hist[i][j] != v) c = 1'b0;
        if (c) comm[i] = v;
        done_m[i] = 1'b0;
        if (k == ld_at[i] + 2) begin
          led_m[i]  = {1'b0, op_m[i][7:4]} + {1'b0, op_m[i][3:0]};
          done_m[i] = 1'b1;
          smp_at[i] = k;
        end
        if ((c || pend[i]) && k >= free_at[i]) begin
          op_m[i] = comm[i]; ld_at[i] = k; free_at[i] = k + 3; pend[i] = 1'b0;
        end else if (c) begin
          pend[i] = 1'b1;
        end
        for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = s;
      end
    end
    #1;
  endtask

  function automatic logic [14:0] exp_vec(int i);
    logic [4:0] l;
    logic       b;
    l = led_m[i];
`ifdef CARRY_BLINK_EN
    if (((k - smp_at[i]) / BLINK_DIV) % 2 != 0) l[4] = 1'b0;
`endif
    b = (k >= ld_at[i]) && (k <= ld_at[i] + 1);
    return {op_m[i], l, b, done_m[i]};
  endfunction

  task automatic test_reset();
    int dones;
    dones = 0;
    rst = 1'b1; sw = 8'h00;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs[i] !== 15'd0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h want 0", i, obs[i]);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus0.done) dones++;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL reset_idle dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_basic();
    int dones, busys;
    dones = 0; busys = 0;
    sw = 8'h25;
    for (int n = 0; n < 12; n++) begin
      tick();
      dones += int'(bus0.done);
      busys += int'(bus0.busy);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL basic dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
      if (n == 5 || n == 6) begin
        n_chk++;
        if ({bus0.op_a, bus0.op_b} !== ((n == 6) ? 8'h25 : 8'h00)) begin
          n_fail++; $display("FAIL basic_op_load edge %0d: got %h", n, {bus0.op_a, bus0.op_b});
        end
      end
      if (n == 8) begin
        n_chk++;
        if ({bus0.led, bus0.done} !== {5'b00111, 1'b1}) begin
          n_fail++; $display("FAIL basic_led edge 8: got led %b done %b want 00111 1", bus0.led, bus0.done);
        end
      end
    end
    n_chk++;
    if (dones !== 1 || busys !== 2) begin
      n_fail++; $display("FAIL basic_counts: got done %0d busy %0d want 1 2", dones, busys);
    end
  endtask

  task automatic test_carry();
    logic [11:0] wide;
    logic [7:0]  vals [2];
    logic [4:0]  want [2];
    wide = 12'h2ab;
    vals[0] = wide[7:0]; vals[1] = 8'h6C;
    want[0] = 5'd21;     want[1] = 5'd18;
    for (int p = 0; p < 2; p++) begin
      int dones;
      dones = 0;
      sw = vals[p];
      for (int n = 0; n < 12; n++) begin
        tick();
        dones += int'(bus0.done);
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (obs[i] !== exp_vec(i)) begin
            n_fail++; $display("FAIL carry dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
          end
        end
      end
      n_chk++;
      if (bus0.led !== want[p] || dones !== 1) begin
        n_fail++; $display("FAIL carry_led %h: got led %0d done %0d want %0d 1", vals[p], bus0.led, dones, want[p]);
      end
    end
  endtask

  task automatic test_glitch();
    int dones;
    dones = 0;
    sw = 8'h25;
    for (int n = 0; n < 30; n++) begin
      if (n == 12) sw = 8'hFF;
      if (n == 15) sw = 8'h25;
      tick();
      if (n >= 12) dones += int'(bus0.done);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL glitch dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (dones !== 0 || bus0.led !== 5'b00111) begin
      n_fail++; $display("FAIL glitch_filter: got done %0d led %b want 0 00111", dones, bus0.led);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen [$];
    sw = 8'h11;
    for (int n = 0; n < 16; n++) begin
      if (n == 2) sw = 8'h33;
      tick();
      if (bus1.done) seen.push_back(bus1.led);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL b2b dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (seen.size() != 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d want 2", seen.size());
    end else begin
      n_chk++;
      if (seen[0] !== 5'd2 || seen[1] !== 5'd6) begin
        n_fail++; $display("FAIL b2b_leds: got %0d %0d want 2 6", seen[0], seen[1]);
      end
    end
    n_chk++;
    if ({bus1.op_a, bus1.op_b} !== 8'h33) begin
      n_fail++; $display("FAIL b2b_final_op: got %h want 33", {bus1.op_a, bus1.op_b});
    end
  endtask

  task automatic test_carry_blink();
    sw = 8'hFF;
    for (int n = 0; n < 40; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL blink dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
`ifdef CARRY_BLINK_EN
    if (bus0.led[3:0] !== 4'b1110) begin
      n_fail++; $display("FAIL blink_low: got %b want 1110", bus0.led[3:0]);
    end
`else
    if (bus0.led !== 5'b11110) begin
      n_fail++; $display("FAIL steady_ff: got %b want 11110", bus0.led);
    end
`endif
  endtask

  task automatic test_reset_mid();
    sw = 8'h12;
    for (int n = 0; n < 8; n++) tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs[i] !== 15'd0) begin
        n_fail++; $display("FAIL reset_mid dut%0d: got %h want 0", i, obs[i]);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL reset_recover dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3, 0) == 0) sw = 8'($urandom);
      else if ($urandom_range(7, 0) == 0) sw = sw ^ 8'(1 << $urandom_range(7, 0));
      tick();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL random dut%0d cyc %0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_glitch();
    test_back_to_back();
    test_carry_blink();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_adder_ctrl.md
Name: switch_adder_ctrl

Overview:
Sequencing controller for the lab's nibble-adder datapath, which computes led[4:0] = switch[7:4] + switch[3:0].
- Synchronizes and debounces the 8 slide switches.
- Detects a stable change, drives the two 4-bit operands to the external combinational adder, samples its 5-bit sum one cycle later and holds it on the LEDs.
- Sits between the board switch pins, the adder instance and the LED pins.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required before a switch value is committed (legal range 1..255).
BLINK_DIV, 8, half-period in clk cycles of the carry blink; used only with CARRY_BLINK_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
switch  input  8  raw asynchronous slide-switch value.
op_a  output  4  operand A to adder, equal to committed switch[7:4].
op_b  output  4  operand B to adder, equal to committed switch[3:0].
sum_in  input  5  adder result (combinational from op_a/op_b).
led  output  5  displayed sum, registered.
busy  output  1  high while in DRIVE or SAMPLE.
done  output  1  one-cycle pulse when led is updated.

Behaviour:
Reset (rst=1 at a rising edge) clears:
- sync1, sync2, cand, committed, cnt and pending to 0.
- state to IDLE.
- op_a, op_b, led, busy and done to 0.
- Reset mid-operation aborts DRIVE/SAMPLE and does not update led.

Synchronizer:
- Two flops, sync1 then sync2.
- No logic reads sync1 directly.

Debounce:
- If sync2 != cand: cand <= sync2, cnt <= 0.
- Else if cnt < DEBOUNCE_CYCLES-1: cnt increments.
- Else, if cand != committed: committed <= cand and a commit event fires for that edge only. cnt saturates at DEBOUNCE_CYCLES-1.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never commits.

FSM (IDLE, DRIVE, SAMPLE):
- IDLE: on a commit event or pending=1, load op_a/op_b from the new committed value (same edge), clear pending, and go to DRIVE.
- DRIVE: one cycle so the adder settles, then go to SAMPLE.
- SAMPLE: led <= sum_in, done <= 1 for exactly one cycle, then go to IDLE.
- A commit event while in DRIVE or SAMPLE sets pending. Pending is one deep; the latest committed value wins.
- A commit event and the return to IDLE on the same edge leaves pending set, so it is serviced on the next edge.
- op_a/op_b change only on an IDLE->DRIVE transition.

Latency:
- Switch change settled before rising edge 0.
- Operands load at edge DEBOUNCE_CYCLES+2.
- led and done become valid after edge DEBOUNCE_CYCLES+4.
- With the default of 4: led valid after the 9th edge.

Widths:
- The sum is computed externally (zero-extended 4+4 -> 5); the controller does not recompute it.
- led[4] is the carry bit.
- Maximum sum is 5'd30.
- Changes that restore the already-committed value do not re-trigger.

Optional Feature:
CARRY_BLINK_EN
- Defined: when the latched led[4]=1, the led[4] output toggles every BLINK_DIV cycles, starting from on at the SAMPLE edge. led[3:0] stays steady. The blink counter resets on rst and on each SAMPLE.
- Undefined: led[4] is a steady copy of the latched sum bit 4. No blink counter is synthesized.

Test Plan:
Use an ideal-adder model on sum_in throughout.
1. Reset -> led=0, op_a=0, op_b=0, busy=0, done=0. Holding switch=8'h00 for 20 cycles -> no done pulse.
2. Set switch=8'h25 -> op_a=2, op_b=5 load at edge 6; led=5'b00111 and a single done pulse after edge 8; busy high for exactly 2 cycles.
3. Set switch=8'h2ab (truncates to 8'hAB) -> led=5'd21 (5'b10101). Then switch=8'h6C -> led=5'd18 (5'b10010), one done per change.
4. Glitch: switch=8'h25 steady, pulse to 8'hFF for 3 cycles, return to 8'h25 -> no done, led unchanged.
5. Back-to-back changes: switch=8'h11, then 8'h33 timed so its commit lands in DRIVE -> led=2 then led=6, two done pulses, final op_a=3, op_b=3.
6. With CARRY_BLINK_EN defined, switch=8'hFF -> led[3:0]=4'b1110 steady and led[4] toggling every 8 cycles. Undefined -> led=5'b11110 steady. Assert rst mid-SAMPLE -> all outputs 0.
